// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Select encoding matches the external 2:1 address/write-data muxes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SEL_FETCH = 1'b1;
  localparam logic SEL_DATA  = 1'b0;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick: a lone request wins outright,
// a contested pick goes to the requester that did not win last time.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = (req0 && req1) ? ~last_grant : req1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sequencing one memory transaction at a time between
// instruction fetch (0) and data (1), with a BUSY-cycle timeout abort.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic mem_ack,
  output logic sel,
  output logic mem_req,
  output logic ack0,
  output logic ack1,
  output logic busy,
  output logic timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sel, r_mem_req, r_ack0, r_ack1, r_busy, r_err;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sel_nxt, w_mem_req_nxt, w_ack0_nxt, w_ack1_nxt;
  logic             w_busy_nxt, w_err_nxt, w_last_grant_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_grant_valid, w_grant_id;
  logic             w_timeout, w_finish;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  assign w_timeout = (r_cnt == CNT_LAST);
  assign w_finish  = mem_ack || w_timeout;

  // State and registered-output update
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_sel        <= SEL_FETCH;
      r_mem_req    <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_busy       <= w_busy_nxt;
      r_err        <= w_err_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_state_nxt = BUSY;
      BUSY:    if (w_finish)      w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // mem_ack wins over a simultaneous timeout, so err only when no ack arrived
  always_comb begin
    w_sel_nxt        = r_sel;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_mem_req_nxt    = 1'b0;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_sel_nxt        = w_grant_id ? SEL_DATA : SEL_FETCH;
          w_last_grant_nxt = w_grant_id;
          w_cnt_nxt        = '0;
          w_mem_req_nxt    = 1'b1;
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_finish) begin
          w_ack0_nxt = (r_sel == SEL_FETCH);
          w_ack1_nxt = (r_sel == SEL_DATA);
          w_err_nxt  = !mem_ack;
        end else begin
          w_mem_req_nxt = 1'b1;
        end
      end
      default: ;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign sel         = r_sel;
  assign mem_req     = r_mem_req;
  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign busy        = r_busy;
  assign timeout_err = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever an ack appears.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, mem_ack = 1'b0;
  logic sel, mem_req, ack0, ack1, busy, timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .mem_ack     (mem_ack),
    .sel         (sel),
    .mem_req     (mem_req),
    .ack0        (ack0),
    .ack1        (ack1),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct packed {
    logic id;
    logic err;
  } exp_t;

  exp_t sbq[$];
  int   nchecks = 0;
  int   nerrors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion monitor
  always @(negedge clk) begin
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      if (sbq.size() == 0) begin
        nchecks++;
        nerrors++;
        $display("FAIL unexpected_ack: ack0=%0b ack1=%0b err=%0b, expected no completion", ack0, ack1, timeout_err);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("ack0", 32'(ack0), 32'(!e.id));
        check("ack1", 32'(ack1), 32'(e.id));
        check("timeout_err", 32'(timeout_err), 32'(e.err));
        check("sel_at_ack", 32'(sel), 32'(!e.id));
      end
    end else if (timeout_err === 1'b1) begin
      nchecks++;
      nerrors++;
      $display("FAIL lone_timeout_err: got 1 expected 0 without ack");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (mem_req) break;
    end
    if (!mem_req) begin
      nchecks++;
      nerrors++;
      $display("FAIL grant_timeout: mem_req got 0 expected 1 within 10 cycles");
    end
  endtask

  // k < 0 means memory never answers
  task automatic serve(input int k, output int nreq, output int lat);
    nreq = 0;
    lat  = -1;
    for (int c = 0; c < 40; c++) begin
      if (mem_req) nreq++;
      mem_ack = (c == k);
      tick();
      if (ack0 || ack1) begin
        lat = c + 1;
        break;
      end
    end
    mem_ack = 1'b0;
    if (lat < 0) begin
      nchecks++;
      nerrors++;
      $display("FAIL ack_wait: no ack within 40 cycles, expected one");
    end
  endtask

  initial begin
    int n, nreq, lat, prev;
    exp_t e;

    repeat (3) tick();
    check("rst_sel", 32'(sel), 1);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack0", 32'(ack0), 0);
    check("rst_ack1", 32'(ack1), 0);
    check("rst_err", 32'(timeout_err), 0);
    reset = 1'b1;
    tick();

    // req0 alone, mem_ack two cycles after mem_req rises
    req0 = 1'b1;
    wait_grant(n);
    check("t1_grant_lat", 32'(n), 1);
    check("t1_sel", 32'(sel), 1);
    check("t1_busy", 32'(busy), 1);
    e.id = 1'b0; e.err = 1'b0; sbq.push_back(e);
    serve(2, nreq, lat);
    req0 = 1'b0;
    check("t1_mem_req_cycles", 32'(nreq), 3);
    check("t1_ack_lat", 32'(lat), 3);
    check("t1_mem_req_done", 32'(mem_req), 0);
    tick();
    check("t1_ack0_single", 32'(ack0), 0);
    check("t1_busy_idle", 32'(busy), 0);

    // Reset, then both held high: 0,1,0,1 every 3 cycles
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(n);
      check("t2_sel_order", 32'(sel), 32'((i % 2) == 0));
      e.id = logic'(i % 2); e.err = 1'b0; sbq.push_back(e);
      serve(0, nreq, lat);
      check("t2_ack_lat", 32'(lat), 1);
      if (i > 0) check("t2_ack_spacing", 32'(cyc - prev), 3);
      prev = cyc;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("t2_busy_idle", 32'(busy), 0);

    // req1 alone, memory silent: timeout abort after 15 BUSY cycles
    req1 = 1'b1;
    wait_grant(n);
    check("t3_sel", 32'(sel), 0);
    e.id = 1'b1; e.err = 1'b1; sbq.push_back(e);
    serve(-1, nreq, lat);
    req1 = 1'b0;
    check("t3_mem_req_cycles", 32'(nreq), 15);
    check("t3_ack_lat", 32'(lat), 15);
    tick();
    check("t3_busy_idle", 32'(busy), 0);
    check("t3_err_single", 32'(timeout_err), 0);

    // mem_ack on the timeout cycle completes normally
    req1 = 1'b1;
    wait_grant(n);
    e.id = 1'b1; e.err = 1'b0; sbq.push_back(e);
    serve(14, nreq, lat);
    req1 = 1'b0;
    check("t4_mem_req_cycles", 32'(nreq), 15);
    check("t4_ack_lat", 32'(lat), 15);
    tick();

    // Reset during a req1 transaction
    req1 = 1'b1;
    wait_grant(n);
    check("t5_sel_before", 32'(sel), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("t5_mem_req", 32'(mem_req), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_sel", 32'(sel), 1);
    check("t5_ack1", 32'(ack1), 0);
    check("t5_err", 32'(timeout_err), 0);
    req0 = 1'b1;
    tick();
    reset = 1'b1;
    wait_grant(n);
    check("t5_contest_sel", 32'(sel), 1);
    e.id = 1'b0; e.err = 1'b0; sbq.push_back(e);
    serve(0, nreq, lat);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    // mem_ack in IDLE and a request withdrawn before sampling are ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t6_idle_ack_busy", 32'(busy), 0);
    check("t6_idle_ack_mem_req", 32'(mem_req), 0);
    req0 = 1'b1;
    #2;
    req0 = 1'b0;
    tick();
    check("t6_withdrawn_busy", 32'(busy), 0);
    req0 = 1'b1;
    req1 = 1'b1;
    wait_grant(n);
    check("t6_contest_sel", 32'(sel), 0);
    e.id = 1'b1; e.err = 1'b0; sbq.push_back(e);
    serve(1, nreq, lat);
    req0 = 1'b0;
    req1 = 1'b0;
    check("t6_mem_req_cycles", 32'(nreq), 2);
    check("t6_ack_lat", 32'(lat), 2);

    repeat (3) tick();
    check("scoreboard_empty", 32'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
